serial_adder: RTL



---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/full_adder.sv | 13 +
 rtl/serial_adder.sv | 127 ++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and limits for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell shared across the arithmetic blocks.
module full_adder (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = x ^ y ^ cin;
    assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell, LSB first, WIDTH cycles per op.
// Optional signed-overflow flag on port ovf when SERIAL_ADDER_OVF_EN is defined.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_sh_reg, b_sh_reg, sum_sh_reg, sum_reg;
    logic             carry_reg, cout_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             fa_sum, fa_cout;
    logic             accept, last_bit;

    full_adder u_fa (
        .x    (a_sh_reg[0]),
        .y    (b_sh_reg[0]),
        .cin  (carry_reg),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign accept   = in_valid && (state_reg == IDLE);
    assign last_bit = (state_reg == RUN) && (cnt_reg == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (cnt_reg == CNT_LAST) state_next = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Result registers are loaded only on the final bit so sum/cout stay put
    // while the next operation is shifting through.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            sum_sh_reg <= '0;
            sum_reg    <= '0;
            carry_reg  <= 1'b0;
            cout_reg   <= 1'b0;
            cnt_reg    <= '0;
        end else if (accept) begin
            a_sh_reg  <= a;
            b_sh_reg  <= b;
            carry_reg <= cin;
            cnt_reg   <= '0;
        end else if (state_reg == RUN) begin
            a_sh_reg   <= a_sh_reg >> 1;
            b_sh_reg   <= b_sh_reg >> 1;
            sum_sh_reg <= {fa_sum, sum_sh_reg[WIDTH-1:1]};
            carry_reg  <= fa_cout;
            if (last_bit) begin
                sum_reg  <= {fa_sum, sum_sh_reg[WIDTH-1:1]};
                cout_reg <= fa_cout;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign sum  = sum_reg;
    assign cout = cout_reg;

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_reg;

    // On the MSB, carry_reg is the carry into the sign bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else if (accept) begin
            ovf_reg <= 1'b0;
        end else if (last_bit) begin
            ovf_reg <= carry_reg ^ fa_cout;
        end
    end

    assign ovf = ovf_reg;
`endif

endmodule
